// File: rtl/tpu_fifo_pkg.sv
// Shared FIFO sizing helpers: pointer and occupancy-count widths for any depth.
package tpu_fifo_pkg;

  // Bits needed to address DEPTH entries (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 2) ? 32'd1 : 32'($clog2(depth));
  endfunction

  // Bits needed to hold an occupancy value from 0 to DEPTH inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return 32'($clog2(depth + 1));
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port, no reset.
module stream_fifo_mem
  import tpu_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ptr_width(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic [ptr_width(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]             rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents deliberately survive reset and flush
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO with optional registered output stage and occupancy flags.
module stream_fifo
  import tpu_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned OUT_REG  = 0
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        flush,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WIDTH-1:0]            s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WIDTH-1:0]            m_data,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        almost_full,
  output logic                        almost_empty
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic             push;
  logic             pop;
  logic             mem_rd;
  logic             mem_we;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [WIDTH-1:0] rd_data;

  // Pointer increment with explicit wrap so non-power-of-two depths use every entry
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready depends on registered occupancy only, never on m_ready
  assign s_ready      = (cnt_q < CNT_FULL);
  assign push         = s_valid && s_ready;
  assign pop          = m_valid && m_ready;
  assign mem_we       = push && !flush;
  assign count        = cnt_q;
  assign almost_full  = (cnt_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (cnt_q <= CNT_W'(AE_LEVEL));

  stream_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (s_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  if (OUT_REG != 0) begin : g_out_reg
    logic             ovalid_q;
    logic [WIDTH-1:0] odata_q;

    // Storage is read whenever the output register is empty or being drained
    assign mem_rd  = (mem_cnt_q != '0) && (!ovalid_q || m_ready);
    assign m_valid = ovalid_q;
    assign m_data  = odata_q;

    // Output register: refill in the same edge it is popped to avoid bubbles
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        ovalid_q <= 1'b0;
        odata_q  <= '0;
      end else if (flush) begin
        ovalid_q <= 1'b0;
      end else if (mem_rd) begin
        ovalid_q <= 1'b1;
        odata_q  <= rd_data;
      end else if (pop) begin
        ovalid_q <= 1'b0;
      end
    end
  end else begin : g_fwft
    assign mem_rd  = pop;
    assign m_valid = (mem_cnt_q != '0);
    assign m_data  = rd_data;
  end

  // Next pointers and occupancy; flush overrides any push or pop in its cycle
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      mem_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (mem_rd) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (!push && pop) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      if (push && !mem_rd) begin
        mem_cnt_d = mem_cnt_q + CNT_W'(1);
      end else if (!push && mem_rd) begin
        mem_cnt_d = mem_cnt_q - CNT_W'(1);
      end
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      mem_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed and random checks of stream_fifo in FWFT (depth 8) and registered-output (depth 5) builds.
module tb_stream_fifo;

  localparam int unsigned W  = 16;
  localparam int unsigned DA = 8;
  localparam int unsigned DB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DEPTH=8, FWFT, AF=6, AE=1
  logic         rstn_a, flush_a, s_valid_a, s_ready_a, m_valid_a, m_ready_a, af_a, ae_a;
  logic [W-1:0] s_data_a, m_data_a;
  logic [3:0]   count_a;

  // Instance B: DEPTH=5, registered output, AF=4, AE=2
  logic         rstn_b, flush_b, s_valid_b, s_ready_b, m_valid_b, m_ready_b, af_b, ae_b;
  logic [W-1:0] s_data_b, m_data_b;
  logic [2:0]   count_b;

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic         mov_b;
  int           dut_pops_b;

  stream_fifo #(.WIDTH(W), .DEPTH(DA), .AF_LEVEL(6), .AE_LEVEL(1), .OUT_REG(0)) u_a (
    .clk(clk), .rstn(rstn_a), .flush(flush_a),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
    .count(count_a), .almost_full(af_a), .almost_empty(ae_a)
  );

  stream_fifo #(.WIDTH(W), .DEPTH(DB), .AF_LEVEL(4), .AE_LEVEL(2), .OUT_REG(1)) u_b (
    .clk(clk), .rstn(rstn_b), .flush(flush_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
    .count(count_b), .almost_full(af_b), .almost_empty(ae_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on A: drive inputs, check outputs against the queue, then advance the model
  task automatic cyc_a(input logic sv, input logic [W-1:0] d, input logic mr, input logic fl);
    logic exp_push, exp_pop;
    s_valid_a = sv; s_data_a = d; m_ready_a = mr; flush_a = fl;
    chk("a_count",   32'(count_a),   32'(qa.size()));
    chk("a_s_ready", 32'(s_ready_a), 32'(qa.size() < DA));
    chk("a_m_valid", 32'(m_valid_a), 32'(qa.size() != 0));
    chk("a_afull",   32'(af_a),      32'(qa.size() >= 6));
    chk("a_aempty",  32'(ae_a),      32'(qa.size() <= 1));
    if (qa.size() != 0) chk("a_m_data", 32'(m_data_a), 32'(qa[0]));
    exp_push = sv && (qa.size() < DA);
    exp_pop  = mr && (qa.size() != 0);
    @(posedge clk);
    if (fl) begin
      qa.delete();
    end else begin
      if (exp_pop)  void'(qa.pop_front());
      if (exp_push) qa.push_back(d);
    end
    @(negedge clk);
    s_valid_a = 1'b0; m_ready_a = 1'b0; flush_a = 1'b0;
  endtask

  // One cycle on B: the output register fills from storage a cycle after a word lands there
  task automatic cyc_b(input logic sv, input logic [W-1:0] d, input logic mr, input logic fl);
    logic exp_push, exp_pop;
    int   stor;
    s_valid_b = sv; s_data_b = d; m_ready_b = mr; flush_b = fl;
    chk("b_count",   32'(count_b),   32'(qb.size()));
    chk("b_s_ready", 32'(s_ready_b), 32'(qb.size() < DB));
    chk("b_m_valid", 32'(m_valid_b), 32'(mov_b));
    chk("b_afull",   32'(af_b),      32'(qb.size() >= 4));
    chk("b_aempty",  32'(ae_b),      32'(qb.size() <= 2));
    if (mov_b) chk("b_m_data", 32'(m_data_b), 32'(qb[0]));
    if (m_valid_b && mr && !fl) dut_pops_b++;
    exp_push = sv && (qb.size() < DB);
    exp_pop  = mov_b && mr;
    stor     = qb.size() - (mov_b ? 1 : 0);
    @(posedge clk);
    if (fl) begin
      qb.delete();
      mov_b = 1'b0;
    end else begin
      if (exp_pop)  void'(qb.pop_front());
      if (exp_push) qb.push_back(d);
      if (stor > 0 && (!mov_b || mr)) mov_b = 1'b1;
      else if (exp_pop)               mov_b = 1'b0;
    end
    @(negedge clk);
    s_valid_b = 1'b0; m_ready_b = 1'b0; flush_b = 1'b0;
  endtask

  initial begin
    rstn_a = 1'b0; flush_a = 1'b0; s_valid_a = 1'b0; m_ready_a = 1'b0; s_data_a = '0;
    rstn_b = 1'b0; flush_b = 1'b0; s_valid_b = 1'b0; m_ready_b = 1'b0; s_data_b = '0;
    mov_b = 1'b0;
    dut_pops_b = 0;
    #2;
    // Reset state on both builds
    chk("a_rst_count",   32'(count_a),   32'd0);
    chk("a_rst_s_ready", 32'(s_ready_a), 32'd1);
    chk("a_rst_m_valid", 32'(m_valid_a), 32'd0);
    chk("a_rst_aempty",  32'(ae_a),      32'd1);
    chk("a_rst_afull",   32'(af_a),      32'd0);
    chk("b_rst_count",   32'(count_b),   32'd0);
    chk("b_rst_m_valid", 32'(m_valid_b), 32'd0);
    chk("b_rst_m_data",  32'(m_data_b),  32'd0);
    chk("b_rst_s_ready", 32'(s_ready_b), 32'd1);
    @(negedge clk);
    rstn_a = 1'b1; rstn_b = 1'b1;
    @(negedge clk);

    // Fill A to capacity with m_ready low, then offer a ninth word
    for (int i = 1; i <= 8; i++) cyc_a(1'b1, W'(i), 1'b0, 1'b0);
    chk("a_full_s_ready", 32'(s_ready_a), 32'd0);
    chk("a_full_count",   32'(count_a),   32'd8);
    cyc_a(1'b1, 16'h0009, 1'b0, 1'b0);
    // Full with pop and push: 0x0001 leaves, 0x0009 refused
    cyc_a(1'b1, 16'h0009, 1'b1, 1'b0);
    chk("a_after_full_pop_count",   32'(count_a),   32'd7);
    chk("a_after_full_pop_s_ready", 32'(s_ready_a), 32'd1);
    chk("a_after_full_pop_head",    32'(m_data_a),  32'h0002);
    cyc_a(1'b0, '0, 1'b0, 1'b0);

    // Drain to three words, then flush together with push and pop
    for (int i = 0; i < 4; i++) cyc_a(1'b0, '0, 1'b1, 1'b0);
    chk("a_pre_flush_count", 32'(count_a), 32'd3);
    cyc_a(1'b1, 16'h00F0, 1'b1, 1'b1);
    chk("a_flush_count",   32'(count_a),   32'd0);
    chk("a_flush_m_valid", 32'(m_valid_a), 32'd0);
    cyc_a(1'b0, '0, 1'b0, 1'b0);

    // Random traffic on A exercises pointer wrap and ordering
    for (int i = 0; i < 60; i++)
      cyc_a(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 10; i++) cyc_a(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges with four words held
    for (int i = 0; i < 4; i++) cyc_a(1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
    chk("a_pre_rst_count", 32'(count_a), 32'd4);
    #2 rstn_a = 1'b0;
    #1;
    chk("a_async_rst_count",   32'(count_a),   32'd0);
    chk("a_async_rst_m_valid", 32'(m_valid_a), 32'd0);
    chk("a_async_rst_s_ready", 32'(s_ready_a), 32'd1);
    chk("a_async_rst_aempty",  32'(ae_a),      32'd1);
    qa.delete();
    @(negedge clk);
    rstn_a = 1'b1;
    @(negedge clk);
    cyc_a(1'b1, 16'h0055, 1'b0, 1'b0);
    cyc_a(1'b0, '0, 1'b1, 1'b0);
    cyc_a(1'b0, '0, 1'b0, 1'b0);

    // B: 0x00AA into empty appears only after the second edge, then one word per cycle
    cyc_b(1'b1, 16'h00AA, 1'b0, 1'b0);
    chk("b_aa_not_yet", 32'(m_valid_b), 32'd0);
    dut_pops_b = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) begin
        chk("b_aa_valid", 32'(m_valid_b), 32'd1);
        chk("b_aa_data",  32'(m_data_b),  32'h00AA);
      end
      cyc_b(1'b1, W'(16'h00B0 + i), 1'b1, 1'b0);
    end
    chk("b_flow_pops", 32'(dut_pops_b), 32'd11);
    for (int i = 0; i < 4; i++) cyc_b(1'b0, '0, 1'b1, 1'b0);
    chk("b_drained_count", 32'(count_b), 32'd0);

    // B: continuous pushes with random m_ready, a flush midway, then drain
    for (int i = 0; i < 40; i++) begin
      if (i == 20) cyc_b(1'b1, W'($urandom), 1'b1, 1'b1);
      else         cyc_b(1'b1, W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 10; i++) cyc_b(1'b0, '0, 1'b1, 1'b0);
    chk("b_final_count",   32'(count_b),   32'd0);
    chk("b_final_m_valid", 32'(m_valid_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
